// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment by control-token hunting, lock tracking
// and 10b->8b / control decode. One instance per TMDS data pair.
module tmds_channel_decoder #(
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned SEARCH_WINDOW = 2048
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] raw_word,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de,
  output logic       locked,
  output logic [3:0] align_offset
);

  localparam int unsigned RUN_W = 8;
  localparam int unsigned WIN_W = 16;
  localparam int unsigned OFF_W = 4;

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [9:0]         prev_q, q_q, q_d;
  logic [OFF_W-1:0]   offset_q, offset_d, offset_nxt;
  logic [RUN_W-1:0]   run_q, run_d, run_inc;
  logic [WIN_W-1:0]   win_q, win_d, win_inc;
  logic [7:0]         data_q, data_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               de_q, de_d;
  logic               locked_q, locked_d;
  logic               is_tok;
  logic [1:0]         tok_val;
  logic [19:0]        window;

  // 10b->8b data character decode (XOR/XNOR chain after optional inversion)
  function automatic logic [7:0] tmds_decode(input logic [9:0] c);
    logic [7:0] d;
    logic [7:0] r;
    d    = c[9] ? ~c[7:0] : c[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = c[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

  // Classify the registered character as one of the four control tokens
  always_comb begin
    is_tok  = 1'b0;
    tok_val = 2'b00;
    case (q_q)
      10'b1101010100: begin is_tok = 1'b1; tok_val = 2'b00; end
      10'b0010101011: begin is_tok = 1'b1; tok_val = 2'b01; end
      10'b0101010100: begin is_tok = 1'b1; tok_val = 2'b10; end
      10'b1010101011: begin is_tok = 1'b1; tok_val = 2'b11; end
      default:        begin is_tok = 1'b0; tok_val = 2'b00; end
    endcase
  end

  // Search/lock FSM, offset stepping, and the registered output stage
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    run_d      = run_q;
    win_d      = win_q;
    data_d     = 8'h00;
    ctrl_d     = 2'b00;
    de_d       = 1'b0;
    run_inc    = run_q + RUN_W'(1);
    win_inc    = win_q + WIN_W'(1);
    offset_nxt = (offset_q == OFF_W'(9)) ? OFF_W'(0) : offset_q + OFF_W'(1);

    case (state_q)
      ST_SEARCH: begin
        run_d = is_tok ? run_inc : RUN_W'(0);
        win_d = win_inc;
        if (is_tok && (run_inc == RUN_W'(LOCK_COUNT))) begin
          state_d = ST_LOCKED;
          win_d   = WIN_W'(0);
        end else if (win_inc == WIN_W'(SEARCH_WINDOW - 1)) begin
          offset_d = offset_nxt;
          run_d    = RUN_W'(0);
          win_d    = WIN_W'(0);
        end
      end
      ST_LOCKED: begin
        if (is_tok) begin
          win_d = WIN_W'(0);
        end else begin
          win_d = win_inc;
          if (win_inc == WIN_W'(SEARCH_WINDOW - 1)) begin
            state_d  = ST_SEARCH;
            offset_d = offset_nxt;
            run_d    = RUN_W'(0);
            win_d    = WIN_W'(0);
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    // Output follows the next state so lock/unlock and data move on one edge
    if (state_d == ST_LOCKED) begin
      ctrl_d = ctrl_q;
      if (is_tok) begin
        ctrl_d = tok_val;
      end else begin
        de_d   = 1'b1;
        data_d = tmds_decode(q_q);
      end
    end
    locked_d = (state_d == ST_LOCKED);

    // The new offset is applied to the very next character load
    window = {raw_word, prev_q};
    q_d    = 10'(window >> offset_d);
  end

  // Pipeline and state registers
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SEARCH;
      prev_q   <= '0;
      q_q      <= '0;
      offset_q <= '0;
      run_q    <= '0;
      win_q    <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= raw_word;
      q_q      <= q_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      win_q    <= win_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      de_q     <= de_d;
      locked_q <= locked_d;
    end
  end

  assign data_out     = data_q;
  assign ctrl_out     = ctrl_q;
  assign de           = de_q;
  assign locked       = locked_q;
  assign align_offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: serialized character stream cut at a
// chosen bit offset, with hand-computed expected outputs.
module tb_tmds_channel_decoder;

  localparam int unsigned LC = 8;
  localparam int unsigned SW = 64;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic       clk;
  logic       reset;
  logic [9:0] raw_word;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de;
  logic       locked;
  logic [3:0] align_offset;

  int errs   = 0;
  int checks = 0;

  bit bq[$];

  typedef struct packed {
    logic       v;
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
  } exp_t;
  exp_t ep0, ep1;

  logic [9:0] dchar [0:5] = '{10'h100, 10'h200, 10'h100, 10'h200, 10'h101, 10'h2FF};
  logic [7:0] dexp  [0:5] = '{8'h00,   8'hFF,   8'h00,   8'hFF,   8'h03,   8'hFE};
  logic [9:0] toks  [0:3] = '{TOK00, TOK01, TOK10, TOK11};

  tmds_channel_decoder #(.LOCK_COUNT(LC), .SEARCH_WINDOW(SW)) dut (
    .clk_pixel    (clk),
    .reset        (reset),
    .raw_word     (raw_word),
    .data_out     (data_out),
    .ctrl_out     (ctrl_out),
    .de           (de),
    .locked       (locked),
    .align_offset (align_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Restart the serial stream with p leading pad bits (sets the wire offset)
  task automatic restart(input int p);
    bq.delete();
    for (int i = 0; i < p; i++) bq.push_back(1'b0);
    ep0 = '0;
    ep1 = '0;
  endtask

  // Serialize one character (LSB first) and present the next 10-bit word
  task automatic tick(input logic [9:0] ch);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) bq.push_back(ch[i]);
    for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
    raw_word = w;
    @(posedge clk);
    #1;
  endtask

  // Tick and compare outputs against the character sent two ticks earlier
  task automatic tick_chk(input string tag, input logic [9:0] ch, input logic v,
                          input logic e_de, input logic [7:0] e_d, input logic [1:0] e_c);
    tick(ch);
    if (ep1.v) begin
      check({tag, "_de"},   32'(de),       32'(ep1.de));
      check({tag, "_data"}, 32'(data_out), 32'(ep1.d));
      check({tag, "_ctrl"}, 32'(ctrl_out), 32'(ep1.c));
    end
    ep1 = ep0;
    ep0 = '{v: v, de: e_de, d: e_d, c: e_c};
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    raw_word = '0;
    #4;
    reset    = 1'b0;
  endtask

  task automatic wait_lock(input logic [9:0] ch, input int budget, output int n);
    n = 0;
    while (locked !== 1'b1 && n < budget) begin
      tick(ch);
      n++;
    end
  endtask

  int n;
  int t;

  initial begin
    reset    = 1'b1;
    raw_word = '0;
    ep0      = '0;
    ep1      = '0;
    #12;

    // Offset 3 lock, data pattern, then loss of lock
    do_reset();
    check("rst_locked", 32'(locked), 0);
    check("rst_de", 32'(de), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_ctrl", 32'(ctrl_out), 0);
    check("rst_offset", 32'(align_offset), 0);
    restart(3);
    wait_lock(TOK00, 3*SW + LC + 2, n);
    check("off3_lock", 32'(locked), 1);
    check("off3_offset", 32'(align_offset), 3);
    for (int i = 0; i < 4; i++) tick_chk("blank3", TOK00, 1'b1, 1'b0, 8'h00, 2'b00);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 6; i++) tick_chk("data3", dchar[i], 1'b1, 1'b1, dexp[i], 2'b00);
    for (int i = 0; i < 2; i++) tick_chk("tail3", TOK00, 1'b1, 1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 2; i++) tick_chk("tail3", TOK00, 1'b0, 1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 8; i++) tick(TOK00);
    for (int k = 1; k <= int'(SW) + 3; k++) begin
      tick(10'h100);
      if (k == int'(SW)) check("loss_still_locked", 32'(locked), 1);
      if (k == int'(SW) + 1) begin
        check("loss_fall", 32'(locked), 0);
        check("loss_offset", 32'(align_offset), 4);
      end
      if (k == int'(SW) + 3) begin
        check("loss_de", 32'(de), 0);
        check("loss_data", 32'(data_out), 0);
      end
    end

    // Offset 0, all four tokens, then data with held ctrl
    do_reset();
    restart(0);
    for (int j = 0; j < 16; j++) begin
      tick_chk("tok4", toks[j % 4], 1'(j >= 7), 1'b0, 8'h00, 2'(j % 4));
      if (j == 8) check("tok4_prelock", 32'(locked), 0);
      if (j == 9) check("tok4_lock", 32'(locked), 1);
    end
    for (int j = 0; j < 2; j++) tick_chk("hold4", 10'h101, 1'b1, 1'b1, 8'h03, 2'b11);
    for (int j = 0; j < 2; j++) tick_chk("hold4", TOK00, 1'b1, 1'b0, 8'h00, 2'b00);
    for (int j = 0; j < 2; j++) tick_chk("hold4", TOK00, 1'b0, 1'b0, 8'h00, 2'b00);

    // Near-miss run: LC-1 tokens, a data word, then LC tokens
    do_reset();
    restart(0);
    for (int j = 0; j < 18; j++) begin
      t = j;
      tick((t == LC - 1) ? 10'h100 : TOK10);
      if (j == 8)  check("near_first_run", 32'(locked), 0);
      if (j == 16) check("near_prelock", 32'(locked), 0);
      if (j == 17) begin
        check("near_lock", 32'(locked), 1);
        check("near_ctrl", 32'(ctrl_out), 2'b10);
      end
    end

    // Wrap-around: lock at 9, lose lock, offset wraps to 0, relock at 9
    do_reset();
    restart(9);
    wait_lock(TOK00, 10*SW + LC + 2, n);
    check("wrap_lock", 32'(locked), 1);
    check("wrap_offset", 32'(align_offset), 9);
    n = 0;
    while (locked === 1'b1 && n < int'(SW) + 4) begin
      tick(10'h100);
      n++;
    end
    check("wrap_unlock", 32'(locked), 0);
    check("wrap_to_zero", 32'(align_offset), 0);
    wait_lock(TOK00, 10*SW + LC + 2, n);
    check("wrap_relock", 32'(locked), 1);
    check("wrap_reoffset", 32'(align_offset), 9);
    check("wrap_relock_late", 32'(n >= 9*(int'(SW) - 1)), 1);

    // Asynchronous reset while locked at offset 5
    do_reset();
    restart(5);
    wait_lock(TOK11, 10*SW + LC + 2, n);
    check("rst5_lock", 32'(locked), 1);
    check("rst5_offset", 32'(align_offset), 5);
    for (int j = 0; j < 4; j++) tick(10'h200);
    check("rst5_pre_de", 32'(de), 1);
    check("rst5_pre_data", 32'(data_out), 8'hFF);
    check("rst5_pre_ctrl", 32'(ctrl_out), 2'b11);
    #3;
    reset = 1'b1;
    #1;
    check("arst_locked", 32'(locked), 0);
    check("arst_de", 32'(de), 0);
    check("arst_data", 32'(data_out), 0);
    check("arst_ctrl", 32'(ctrl_out), 0);
    check("arst_offset", 32'(align_offset), 0);
    #1;
    reset = 1'b0;
    wait_lock(TOK11, 10*SW + LC + 2, n);
    check("rst5_relock", 32'(locked), 1);
    check("rst5_reoffset", 32'(align_offset), 5);
    check("rst5_relock_late", 32'(n >= 5*(int'(SW) - 1)), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the TMDS serializer path: recovers one TMDS channel from an unaligned 10-bit parallel word stream, such as an IDES10 fed by one HDMI/DVI data pair.
- Finds the character boundary by hunting for DVI control tokens.
- Holds lock and reports the chosen bit offset.
- Decodes each aligned 10-bit character to 8-bit pixel data or 2-bit control plus a data-enable.
- Sits between the deserializer primitive and the video-capture logic; instantiate one per channel.

## Interface
- LOCK_COUNT, 8: consecutive control tokens required at one offset to declare lock (2..255).
- SEARCH_WINDOW, 2048: cycles allowed per offset while searching, and the token-free cycles tolerated while locked (must exceed one video line; 16..65535).
- clk_pixel  input  1  pixel clock; one 10-bit word per cycle.
- reset  input  1  asynchronous, active-high reset.
- raw_word  input  10  deserialized bits; bit 0 is earliest on the wire (same order as the serializer's D0 first).
- data_out  output  8  decoded pixel byte; 0 when de=0.
- ctrl_out  output  2  {C1,C0} of the most recent control token; holds during data.
- de  output  1  1 = data_out valid video data this cycle.
- locked  output  1  alignment lock.
- align_offset  output  4  current bit offset, 0..9.

## Operation
- prev_word register holds raw_word from the previous cycle; window[19:0] = {raw_word, prev_word}.
- Aligned word at offset k is q = window[k+9:k].
- Control tokens (q[9:0]):
  - 10'b1101010100 -> ctrl 00
  - 10'b0010101011 -> ctrl 01
  - 10'b0101010100 -> ctrl 10
  - 10'b1010101011 -> ctrl 11
  - Any other value is a data character.
- Data decode:
  - d = q[9] ? ~q[7:0] : q[7:0].
  - data[0] = d[0].
  - For i = 1..7: data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- State machine: SEARCH, LOCKED.
- Counters: run_cnt (8-bit), win_cnt (16-bit).
- SEARCH:
  - Each cycle the registered q at align_offset is tested.
  - Token: run_cnt++. Non-token: run_cnt = 0.
  - win_cnt increments every cycle.
  - run_cnt reaching LOCK_COUNT -> LOCKED; win_cnt cleared.
  - Otherwise, win_cnt reaching SEARCH_WINDOW-1 -> align_offset = (align_offset==9) ? 0 : align_offset+1, run_cnt = 0, win_cnt = 0.
  - Lock wins if both conditions occur on the same cycle.
- LOCKED:
  - A token clears win_cnt; any other word increments it.
  - win_cnt reaching SEARCH_WINDOW-1 -> SEARCH with align_offset advanced by one (wrap 9->0) and run_cnt = 0.
  - align_offset never changes while locked.
- Output stage, registered; only active when the state is LOCKED:
  - Token: de=0, data_out=0, ctrl_out=token value.
  - Data: de=1, data_out=decoded, ctrl_out held.
  - When not LOCKED: de=0, data_out=0, ctrl_out=0.
- Reset (async assert, released synchronously to clk_pixel externally):
  - State SEARCH.
  - align_offset, run_cnt, win_cnt = 0.
  - prev_word and the q register = 0.
  - data_out=0, ctrl_out=0, de=0, locked=0.
  - Reset mid-lock fully restarts the search from offset 0.

## Timing
- Stage 0: q formed combinationally from window.
- Stage 1: q registered.
- Stage 2: outputs registered.
- The character whose last bit arrives in raw_word at cycle n appears on data_out/de/ctrl_out at the clk_pixel edge ending cycle n+2 (latency 2).
- locked rises on the same edge as the first de/ctrl_out update for the LOCK_COUNT-th consecutive token.
- locked falls on the edge where win_cnt hits its limit; de=0 from that edge.
- An offset change takes effect on the next q register load; that first word is tested against the new offset.
- Worst-case lock time from reset: 10*SEARCH_WINDOW + LOCK_COUNT + 2 cycles.

## Test plan
- Offset 3 lock:
  - Stimulus: 64 tokens 10'b1101010100, then alternating 8'h00 (10'h100) / 8'hFF (10'h200) characters, serialized and cut with bit offset 3.
  - Required: locked=1 within 3*SEARCH_WINDOW+LOCK_COUNT+2 cycles; align_offset=3; de pattern and data_out 00,FF,00,... with latency 2; ctrl_out=00 during blanking.
- Offset 0, all four tokens:
  - Stimulus: cycle tokens 00, 01, 10, 11 repeatedly.
  - Required: lock within LOCK_COUNT+2 cycles; ctrl_out follows 00,01,10,11; de=0.
- Wrap-around:
  - Stimulus: stream at offset 9, then forced loss of lock.
  - Required: after loss, align_offset steps 9->0; search resumes and relocks at 9 after 9 further windows.
- Loss of lock:
  - Stimulus: after lock, send only 10'h100 for SEARCH_WINDOW cycles.
  - Required: locked falls exactly SEARCH_WINDOW cycles after the last token is registered; de=0 and data_out=0 thereafter.
- Near-miss run:
  - Stimulus: LOCK_COUNT-1 tokens, one data word, then LOCK_COUNT tokens.
  - Required: locked rises only after the second run completes.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while locked at offset 5.
  - Required: all outputs 0 immediately, without waiting for a clock edge; align_offset=0; relock at 5 after 5 windows.
